// File: rtl/riscv_irq_controller.sv
// Fixed-priority interrupt controller: the responder end of the core's irq_req/irq_ret interface.
// Sticky pending bits are filtered by mie. The lowest enabled index is issued as a single
// request pulse. No further request is issued until the core returns with mret.
module riscv_irq_controller #(
   parameter int unsigned N_IRQ = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N_IRQ-1:0] irq_i,
   input  logic [31:0]      mie_i,
   input  logic             irq_ret_i,
   output logic             irq_req_o,
   output logic [31:0]      irq_cause_o,
   output logic [N_IRQ-1:0] irq_ack_o
);

   localparam int unsigned IdxW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

   typedef enum logic {StIdle, StBusy} state_e;

   state_e           state_q, state_d;
   logic [IdxW-1:0]  idx_q, idx_d, win_idx;
   logic [N_IRQ-1:0] pend_q, pend_d;
   logic [N_IRQ-1:0] mie_src, sel, idx_onehot;
   logic [N_IRQ-1:0] ack_q, ack_d;
   logic             req_q, req_d;
   logic             unused_mie;

   assign mie_src    = mie_i[16 +: N_IRQ];
   assign sel        = pend_q & mie_src;
   // Only the upper mie bits that map to sources are used.
   assign unused_mie = ^mie_i;

   // Lowest set index of sel wins. Scanning downwards lets the lowest index overwrite last.
   always_comb begin
      win_idx = '0;
      for (int k = N_IRQ - 1; k >= 0; k--) begin
         if (sel[k]) win_idx = IdxW'(k);
      end
   end

   // One-hot decode of the source in service, used for ack and pending clear.
   always_comb begin
      idx_onehot = '0;
      for (int k = 0; k < N_IRQ; k++) begin
         idx_onehot[k] = (idx_q == IdxW'(k));
      end
   end

   // Next-state logic: a request in IDLE moves to BUSY; mret in BUSY returns to IDLE.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      req_d   = 1'b0;
      ack_d   = '0;
      unique case (state_q)
         StIdle: begin
            if (|sel) begin
               idx_d   = win_idx;
               req_d   = 1'b1;
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (irq_ret_i) begin
               ack_d   = idx_onehot;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Pending update: a new masked assertion wins over the clear from the acknowledge.
   always_comb begin
      pend_d = (pend_q & ~ack_d) | (irq_i & mie_src);
   end

   // State, pending and registered output pulses.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= StIdle;
         idx_q   <= '0;
         pend_q  <= '0;
         req_q   <= 1'b0;
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         req_q   <= req_d;
         ack_q   <= ack_d;
      end
   end

   assign irq_req_o   = req_q;
   assign irq_ack_o   = ack_q;
   assign irq_cause_o = (state_q == StBusy) ? (32'h8000_0010 + 32'(idx_q)) : 32'h0;

endmodule

// File: doc/riscv_irq_controller.md
# riscv_irq_controller

Fixed-priority interrupt controller that is the responder end of the core's `irq_req`/`irq_ret` interrupt interface. It collects peripheral interrupt lines, filters them with the core's `mie` mask and latches them as sticky pending bits. It issues one request pulse to `riscv_core` together with an `mcause` value, then holds off further requests until the core signals `mret`. It sits in `riscv_unit` between the peripheral set and the core and returns a per-source acknowledge to the peripheral that was serviced.

## Interface
- `N_IRQ`, 16: number of interrupt sources; legal range 1..16.
- `clk_i`, in, 1: single clock; all state is updated on its rising edge.
- `rst_i`, in, 1: one clock; reset is asynchronous and active-low.
- `irq_i`, in, N_IRQ: peripheral interrupt lines, synchronous to `clk_i`, active-high; pulses of one cycle are legal.
- `mie_i`, in, 32: core `mie` CSR; bit `16+k` enables source k.
- `irq_ret_i`, in, 1: one-cycle pulse from the core on `mret` execution.
- `irq_req_o`, out, 1: one-cycle interrupt request pulse to the core.
- `irq_cause_o`, out, 32: `mcause` value for the request in service.
- `irq_ack_o`, out, N_IRQ: one-hot, one-cycle acknowledge to the serviced source.

## Operation
- Pending register `pend_q[N_IRQ-1:0]` is set every cycle by `irq_i[k] & mie_i[16+k]`. Bits are sticky and are cleared only by an acknowledge or by reset.
- A masked-off source never sets its pending bit. Clearing a mie bit does not clear an already-set pending bit, but it does block that bit from being selected.
- Selection: `sel = pend_q & mie_i[16+N_IRQ-1:16]`. Lowest index wins (source 0 has the highest priority).
- FSM with two states:
  - IDLE: if `sel != 0`, latch the winning index `idx_q`, assert `irq_req_o` on the next cycle, and go to BUSY.
  - BUSY: ignore all new requests, including higher-priority ones (no nesting). On `irq_ret_i`, clear `pend_q[idx_q]`, pulse `irq_ack_o[idx_q]` on the next cycle, and go to IDLE.
- `irq_cause_o = 32'h8000_0010 + idx_q` while in BUSY. It is 0 in IDLE.
- `irq_ret_i` while in IDLE is ignored: no acknowledge, no state change.
- A new assertion of `irq_i[idx_q]` in the same cycle as the clear from `irq_ret_i` re-sets the pending bit (set wins over clear). The source is then requested again later.
- Changes to `mie_i` during BUSY do not alter `idx_q` or `irq_cause_o`.

## Timing
- Reset values: all outputs are 0, `pend_q` = 0, state = IDLE, `idx_q` = 0.
- Request latency: if `irq_i[k]` and its mie bit are high in cycle N with an empty pending register and IDLE state, then `pend_q[k]` = 1 in N+1. In N+2, `irq_req_o` = 1 for exactly one cycle, `irq_cause_o` is valid, and state = BUSY.
- If `pend_q` is already set in IDLE in cycle N, the request appears in N+1.
- Return: `irq_ret_i` high in cycle M (BUSY) gives `irq_ack_o[idx_q]` = 1 and state = IDLE in M+1. `irq_cause_o` = 0 from M+1.
- The earliest next `irq_req_o` after a return is M+2. No two request pulses are ever closer than 3 cycles.
- `irq_req_o` and `irq_ack_o` are registered outputs. `irq_cause_o` is decoded from registered state only.
- The core samples `irq_req_o` in its pulse cycle. If the core is stalled at that point, it must retain the request internally; this controller does not repeat the pulse.
- Reset mid-operation (asserted in any cycle, async): outputs go to 0 immediately and all pending bits are lost. Operation resumes on the first rising edge after deassertion.

## Test plan
- Single source: `mie_i` = 32'h0001_0000, pulse `irq_i[0]` for one cycle at N. Required: `irq_req_o` pulse at N+2, `irq_cause_o` = 32'h8000_0010. Then `irq_ret_i` at M gives `irq_ack_o` = 16'h0001 at M+1 and cause 0.
- Priority: `irq_i[5]` and `irq_i[2]` asserted together, all enabled. Required: first cause 32'h8000_0012; after ret and ack of bit 2, a second request with cause 32'h8000_0015 at ret+2.
- Masking: `mie_i` = 0, `irq_i` = 16'hFFFF for 10 cycles, then `mie_i` = 32'hFFFF_0000. Required: `irq_req_o` never asserts, because pending was never set.
- No nesting: in BUSY on source 7, assert `irq_i[1]`. Required: no request until after ret of source 7, then cause 32'h8000_0011.
- Stray ret: `irq_ret_i` pulse in IDLE. Required: `irq_ack_o` stays 0 and state is unchanged.
- Reset: drop `rst_i` low during BUSY with two bits pending. Required: outputs are 0 asynchronously; after release, no request occurs without new `irq_i` activity.
